// File: rtl/main_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables and mux selects. Define MAIN_FSM_INSTRET_EN to add
// the retired-instruction counter; otherwise instret is tied to zero.
module main_fsm #(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               op,
  input  logic [2:0]               funct3,
  input  logic                     zero,
  input  logic                     mem_ready,
  output logic                     pc_write,
  output logic                     ir_write,
  output logic                     adr_src,
  output logic                     mem_write,
  output logic                     reg_write,
  output logic [1:0]               result_src,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               alu_op,
  output logic                     illegal,
  output logic [3:0]               state,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  state_e state_q, state_d;
  logic   pc_en, ir_en, mem_we, reg_we;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    state_d    = S_FETCH;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_a  = A_PC;
        alu_src_b  = B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALURESULT;
        ir_en      = mem_ready;
        pc_en      = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        alu_op    = ALU_ADD;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_ADD;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        state_d    = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_we     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_we     = 1'b1;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_we     = 1'b1;
      end
      S_JAL: begin
        // Link value PC+4 goes through ALUWB; the target already sits in ALUOut.
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_en      = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000:  pc_en = zero;
          3'b001:  pc_en = ~zero;
          default: pc_en = 1'b0;
        endcase
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are held off for the whole time reset is asserted, not just at the edge.
  assign pc_write  = pc_en  & reset;
  assign ir_write  = ir_en  & reset;
  assign mem_write = mem_we & reset;
  assign reg_write = reg_we & reset;
  assign state     = state_q;

`ifdef MAIN_FSM_INSTRET_EN
  logic                     retire;
  logic [INSTRET_WIDTH-1:0] instret_q;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
      S_MEMWRITE:                 retire = mem_ready;
      default:                    retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + INSTRET_WIDTH'(1);
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Directed self-checking bench for main_fsm: walks each instruction class,
// stalls, branches, trap, reset and counter wrap with INSTRET_WIDTH=4.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  logic [3:0] instret;

  int n_checks = 0;
  int n_fail   = 0;
  int ret      = 0;

  main_fsm #(.INSTRET_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, a, b, alu_op, illegal}
  logic [13:0] ctl;
  assign ctl = {pc_write, ir_write, adr_src, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, illegal};

  localparam logic [13:0] C_RESET    = 14'b0_0_0_0_0_10_00_10_00_0;
  localparam logic [13:0] C_FETCH    = 14'b1_1_0_0_0_10_00_10_00_0;
  localparam logic [13:0] C_FETCH_ST = 14'b0_0_0_0_0_10_00_10_00_0;
  localparam logic [13:0] C_DECODE   = 14'b0_0_0_0_0_00_01_01_00_0;
  localparam logic [13:0] C_MEMADR   = 14'b0_0_0_0_0_00_10_01_00_0;
  localparam logic [13:0] C_MEMREAD  = 14'b0_0_1_0_0_00_00_00_00_0;
  localparam logic [13:0] C_MEMWB    = 14'b0_0_0_0_1_01_00_00_00_0;
  localparam logic [13:0] C_MEMWRITE = 14'b0_0_1_1_0_00_00_00_00_0;
  localparam logic [13:0] C_EXECR    = 14'b0_0_0_0_0_00_10_00_10_0;
  localparam logic [13:0] C_EXECI    = 14'b0_0_0_0_0_00_10_01_10_0;
  localparam logic [13:0] C_ALUWB    = 14'b0_0_0_0_1_00_00_00_00_0;
  localparam logic [13:0] C_JAL      = 14'b1_0_0_0_0_00_01_10_00_0;
  localparam logic [13:0] C_BR_TAKE  = 14'b1_0_0_0_0_00_10_00_01_0;
  localparam logic [13:0] C_BR_NOT   = 14'b0_0_0_0_0_00_10_00_01_0;
  localparam logic [13:0] C_TRAP     = 14'b0_0_0_0_0_00_00_00_00_1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_instret();
`ifdef MAIN_FSM_INSTRET_EN
    return ret[3:0];
`else
    return 4'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Settle combinational outputs, compare state and control word, then advance one edge.
  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [13:0] c);
    #1;
    check({tag, "_state"}, state, st);
    check({tag, "_ctl"}, ctl, c);
    tick();
  endtask

  task automatic fetch_decode(input string tag, input logic [6:0] opc, input logic [2:0] f3);
    mem_ready = 1'b1;
    op        = opc;
    funct3    = f3;
    expect_cycle({tag, "_fetch"}, 4'd0, C_FETCH);
    expect_cycle({tag, "_decode"}, 4'd1, C_DECODE);
  endtask

  task automatic retired(input string tag);
    ret++;
    #1;
    check({tag, "_instret"}, instret, exp_instret());
  endtask

  task automatic run_add(input string tag);
    fetch_decode(tag, 7'b0110011, 3'b000);
    expect_cycle({tag, "_execr"}, 4'd6, C_EXECR);
    expect_cycle({tag, "_aluwb"}, 4'd8, C_ALUWB);
    retired(tag);
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; op = 7'd0; funct3 = 3'd0; zero = 1'b0;

    // Reset held with mem_ready high: enables stay off.
    repeat (2) @(posedge clk);
    #2;
    #1;
    check("rst_state", state, 4'd0);
    check("rst_ctl", ctl, C_RESET);
    check("rst_instret", instret, 4'd0);
    reset = 1'b1;
    #1;
    check("rel_ctl", ctl, C_FETCH);

    // add
    run_add("add");

    // lw with a fetch stall and a 3-cycle memory stall
    mem_ready = 1'b0;
    expect_cycle("fetch_stall", 4'd0, C_FETCH_ST);
    fetch_decode("lw", 7'b0000011, 3'b010);
    expect_cycle("lw_memadr", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_cycle("lw_memread_wait", 4'd3, C_MEMREAD);
    mem_ready = 1'b1;
    expect_cycle("lw_memread_done", 4'd3, C_MEMREAD);
    expect_cycle("lw_memwb", 4'd4, C_MEMWB);
    retired("lw");

    // sw with a 2-cycle memory stall
    fetch_decode("sw", 7'b0100011, 3'b010);
    expect_cycle("sw_memadr", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) expect_cycle("sw_memwrite_wait", 4'd5, C_MEMWRITE);
    #1;
    check("sw_instret_hold", instret, exp_instret());
    mem_ready = 1'b1;
    expect_cycle("sw_memwrite_done", 4'd5, C_MEMWRITE);
    retired("sw");

    // jal
    fetch_decode("jal", 7'b1101111, 3'b000);
    expect_cycle("jal_jal", 4'd9, C_JAL);
    expect_cycle("jal_aluwb", 4'd8, C_ALUWB);
    retired("jal");

    // addi
    fetch_decode("addi", 7'b0010011, 3'b000);
    expect_cycle("addi_execi", 4'd7, C_EXECI);
    expect_cycle("addi_aluwb", 4'd8, C_ALUWB);
    retired("addi");

    // Branches: beq/bne/blt against the zero flag; mem_ready low must not matter.
    fetch_decode("beq_z1", 7'b1100011, 3'b000);
    zero = 1'b1; mem_ready = 1'b0;
    expect_cycle("beq_z1_branch", 4'd10, C_BR_TAKE);
    retired("beq_z1");
    fetch_decode("bne_z1", 7'b1100011, 3'b001);
    zero = 1'b1;
    expect_cycle("bne_z1_branch", 4'd10, C_BR_NOT);
    retired("bne_z1");
    fetch_decode("bne_z0", 7'b1100011, 3'b001);
    zero = 1'b0;
    expect_cycle("bne_z0_branch", 4'd10, C_BR_TAKE);
    retired("bne_z0");
    fetch_decode("blt", 7'b1100011, 3'b100);
    zero = 1'b1;
    expect_cycle("blt_branch", 4'd10, C_BR_NOT);
    retired("blt");

    // Fill the 4-bit counter to 15, then one more retirement wraps it.
    while (ret % 16 != 15) run_add("fill");
    run_add("wrap");
    #1;
    check("wrap_zero", instret, 4'd0);

    // Reset mid-instruction abandons it and clears the counter.
    fetch_decode("abort", 7'b0110011, 3'b000);
    reset = 1'b0;
    ret = 0;
    #1;
    check("abort_state", state, 4'd0);
    check("abort_ctl", ctl, C_RESET);
    check("abort_instret", instret, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    check("abort_no_retire", instret, 4'd0);
    check("abort_refetch", state, 4'd1);
    op = 7'b0110011;
    expect_cycle("abort_decode", 4'd1, C_DECODE);
    expect_cycle("abort_execr", 4'd6, C_EXECR);
    expect_cycle("abort_aluwb", 4'd8, C_ALUWB);
    retired("abort_add");

    // Illegal opcode: stuck in TRAP for 20 cycles whatever mem_ready does.
    fetch_decode("trap", 7'b1111111, 3'b000);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      expect_cycle("trap_hold", 4'd11, C_TRAP);
    end
    reset = 1'b0;
    ret = 0;
    #1;
    check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    check("trap_rst_state", state, 4'd0);
    check("trap_rst_instret", instret, 4'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
